// File: rtl/seq_digit_decoder.sv
// Receive-side checker for the digit-sequence generator: validates each step
// against the generator's transition graph, recovers the a bit, tracks lock and errors.
module seq_digit_decoder #(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [2:0]       din,
  output logic             a_valid,
  output logic             a_out,
  output logic             err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCK} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_N);

  state_t     state;
  logic [2:0] prev;
  logic [3:0] lock_cnt;
  logic [3:0] cnt_inc;
  logic       sym_ok;
  logic       pair_ok;
  logic [1:0] rec;

  function automatic logic is_symbol(input logic [2:0] d);
    return (d == 3'd0) || (d == 3'd2) || (d == 3'd3) || (d == 3'd4) || (d == 3'd5);
  endfunction

  // {recovering pair, recovered bit}
  function automatic logic [1:0] recover(input logic [2:0] p, input logic [2:0] n);
    logic [1:0] r;
    r = 2'b00;
    if      (p == 3'd3 && n == 3'd5) r = 2'b11;
    else if (p == 3'd3 && n == 3'd2) r = 2'b10;
    else if (p == 3'd4 && n == 3'd3) r = 2'b11;
    else if (p == 3'd4 && n == 3'd0) r = 2'b10;
    return r;
  endfunction

  function automatic logic is_legal(input logic [2:0] p, input logic [2:0] n);
    return recover(p, n)[1] ||
           (p == 3'd0 && n == 3'd3) ||
           (p == 3'd5 && n == 3'd2) ||
           (p == 3'd2 && n == 3'd4);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  always_comb begin
    sym_ok  = is_symbol(din);
    pair_ok = is_legal(prev, din);
    rec     = recover(prev, din);
    cnt_inc = (lock_cnt >= LOCK_C) ? LOCK_C : lock_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HUNT;
      prev     <= 3'd0;
      lock_cnt <= 4'd0;
      a_valid  <= 1'b0;
      a_out    <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      a_valid <= 1'b0;
      err     <= 1'b0;
      if (din_valid) begin
        if (!sym_ok) begin
          // Illegal symbol: no usable history, restart the hunt
          err      <= 1'b1;
          err_cnt  <= sat_inc(err_cnt);
          state    <= HUNT;
          lock_cnt <= 4'd0;
          locked   <= 1'b0;
        end else if (state == HUNT) begin
          prev     <= din;
          lock_cnt <= 4'd0;
          state    <= TRACK;
        end else if (pair_ok) begin
          prev     <= din;
          lock_cnt <= cnt_inc;
          if (cnt_inc == LOCK_C) begin
            state  <= LOCK;
            locked <= 1'b1;
          end
          if (rec[1]) begin
            a_valid <= 1'b1;
            a_out   <= rec[0];
          end
        end else begin
          // Bad step but a valid digit: resynchronise on it
          err      <= 1'b1;
          err_cnt  <= sat_inc(err_cnt);
          prev     <= din;
          lock_cnt <= 4'd0;
          state    <= TRACK;
          locked   <= 1'b0;
        end
      end
    end
  end

endmodule
